// File: rtl/sample_pair_packer.sv
// Sample pair packer: turns a serial sample stream (one sample per beat) into
// {even, odd} pairs with sof/eol flags for the first 1D lifting stage.
// Odd-length lines get a symmetric-extension pad x[N] = x[N-2].
// Optional feature macro: SAMPLE_PAIR_PACKER_ERR_EN (adds err_o pulse and an
// input-stability assertion).
module sample_pair_packer #(
    parameter int unsigned DataWidth       = 16,
    parameter int unsigned MaximumSideSize = 512
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 s_ready_o,
    input  logic                 s_valid_i,
    input  logic                 s_sof_i,
    input  logic                 s_eol_i,
    input  logic [DataWidth-1:0] s_data_i,
    input  logic                 m_ready_i,
    output logic                 m_valid_o,
    output logic                 m_sof_o,
    output logic                 m_eol_o,
    output logic [DataWidth-1:0] m_data_even_o,
    output logic [DataWidth-1:0] m_data_odd_o
`ifdef SAMPLE_PAIR_PACKER_ERR_EN
    ,
    output logic                 err_o
`endif
);

    localparam int unsigned PosWidth = $clog2(MaximumSideSize) + 1;
    localparam logic [PosWidth-1:0] PosLast = PosWidth'(MaximumSideSize - 1);

    typedef enum logic {StEven, StOdd} state_e;

    state_e                state_q, state_d;
    logic [DataWidth-1:0]  even_q, even_d;
    logic [DataWidth-1:0]  odd_q, odd_d;
    logic                  pending_sof_q, pending_sof_d;
    logic [PosWidth-1:0]   pos_q, pos_d;

    logic                  m_valid_q;
    logic                  m_sof_q;
    logic                  m_eol_q;
    logic [DataWidth-1:0]  m_even_q;
    logic [DataWidth-1:0]  m_odd_q;

    logic                  accept;
    logic                  restart;
    logic [PosWidth-1:0]   pos_base;
    logic                  at_limit;
    logic                  line_end;
    logic                  load;
    logic                  ld_sof;
    logic                  ld_eol;
    logic [DataWidth-1:0]  ld_even;
    logic [DataWidth-1:0]  ld_odd;

    assign s_ready_o     = !m_valid_q || m_ready_i;
    assign accept        = s_valid_i && s_ready_o;
    // A sof seen while waiting for the odd sample restarts the line at this sample.
    assign restart       = (state_q == StOdd) && s_sof_i;
    assign pos_base      = restart ? '0 : pos_q;
    assign at_limit      = (pos_base == PosLast);
    assign line_end      = s_eol_i || at_limit;

    assign m_valid_o     = m_valid_q;
    assign m_sof_o       = m_sof_q;
    assign m_eol_o       = m_eol_q;
    assign m_data_even_o = m_even_q;
    assign m_data_odd_o  = m_odd_q;

    // Pairing state machine: next state, held samples and output-register load.
    always_comb begin
        state_d       = state_q;
        even_d        = even_q;
        odd_d         = odd_q;
        pending_sof_d = pending_sof_q;
        pos_d         = pos_q;
        load          = 1'b0;
        ld_sof        = 1'b0;
        ld_eol        = 1'b0;
        ld_even       = even_q;
        ld_odd        = odd_q;
        if (accept) begin
            if (state_q == StEven || restart) begin
                if (line_end) begin
                    // Odd-length line ends on an even sample: pad with x[N-2],
                    // or with the sample itself for a single-sample line.
                    load    = 1'b1;
                    ld_even = s_data_i;
                    ld_odd  = (pos_base == '0) ? s_data_i : odd_q;
                    ld_sof  = s_sof_i;
                    ld_eol  = 1'b1;
                    pos_d   = '0;
                    state_d = StEven;
                end else begin
                    even_d        = s_data_i;
                    pending_sof_d = s_sof_i;
                    pos_d         = pos_base + PosWidth'(1);
                    state_d       = StOdd;
                end
            end else begin
                load    = 1'b1;
                ld_even = even_q;
                ld_odd  = s_data_i;
                ld_sof  = pending_sof_q;
                ld_eol  = line_end;
                odd_d   = s_data_i;
                pos_d   = line_end ? '0 : pos_base + PosWidth'(1);
                state_d = StEven;
            end
        end
    end

    // Pairing state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StEven;
            even_q        <= '0;
            odd_q         <= '0;
            pending_sof_q <= 1'b0;
            pos_q         <= '0;
        end else begin
            state_q       <= state_d;
            even_q        <= even_d;
            odd_q         <= odd_d;
            pending_sof_q <= pending_sof_d;
            pos_q         <= pos_d;
        end
    end

    // Single output register: loads a completed pair, clears on transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            m_even_q  <= '0;
            m_odd_q   <= '0;
        end else if (load) begin
            m_valid_q <= 1'b1;
            m_sof_q   <= ld_sof;
            m_eol_q   <= ld_eol;
            m_even_q  <= ld_even;
            m_odd_q   <= ld_odd;
        end else if (m_ready_i) begin
            m_valid_q <= 1'b0;
        end
    end

`ifdef SAMPLE_PAIR_PACKER_ERR_EN
    logic forced_eol;
    logic err_q;

    assign forced_eol = !s_eol_i && at_limit;
    assign err_o      = err_q;

    // Error pulse: mid-pair sof (covers sof+eol in odd state) or forced line end.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && (restart || forced_eol);
        end
    end

`ifndef SYNTHESIS
    // Upstream must hold a stalled beat unchanged.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (s_valid_i && !s_ready_o) |=> $stable({s_data_i, s_sof_i, s_eol_i}));
`endif
`endif

endmodule

// File: doc/sample_pair_packer.md
Name: sample_pair_packer

Overview:
- Feeds processing_unit_1d_row from a serial sample stream: one sample per beat in, one {even, odd} pair per beat out.
- Each pair carries the sof/eol flags the lifting unit expects.
- Odd-length lines get a symmetric-extension pad for the missing odd sample, so every output line has an even number of samples.
- Sits between the line/column reader and the first ProcessingUnit1D stage.

Parameters:
- DataWidth, 16, sample width in bits, signed fixed-point, passed through unchanged.
- MaximumSideSize, 512, maximum samples per line; sizes the line-position counter ($clog2(MaximumSideSize)+1 bits).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- s_ready_o  output  1  upstream ready
- s_valid_i  input  1  upstream valid
- s_sof_i  input  1  first sample of frame
- s_eol_i  input  1  last sample of line
- s_data_i  input  DataWidth  sample
- m_ready_i  input  1  downstream ready
- m_valid_o  output  1  pair valid
- m_sof_o  output  1  pair contains frame's first sample
- m_eol_o  output  1  pair contains line's last sample
- m_data_even_o  output  DataWidth  even-index sample x[2k]
- m_data_odd_o  output  DataWidth  odd-index sample x[2k+1], or pad
- err_o  output  1  protocol error pulse (only with the optional feature)

Behaviour:
- Handshake: input beat accepted when s_valid_i & s_ready_o; output beat transferred when m_valid_o & m_ready_i.
- s_ready_o = !m_valid_o | m_ready_i. Combinational ready, single output register, no skid.
- m_valid_o holds until accepted; outputs are stable while m_valid_o & !m_ready_i.
- Reset (rst_ni low, asynchronous): m_valid_o=0, m_sof_o=0, m_eol_o=0, both data outputs 0. State=EVEN, held registers cleared, pos=0, pending_sof=0.
- State EVEN, on accepted sample:
  - !s_eol_i: latch sample into even_q, pending_sof <= s_sof_i, go ODD. No output.
  - s_eol_i (odd-length line): load output register in the same clock edge with even=sample, odd=odd_q, eol=1, sof=s_sof_i. Stay EVEN, pos <= 0.
  - odd_q is the last odd sample of the line, i.e. x[N-2]: symmetric extension x[N]=x[N-2].
  - If pos==0 (line of length 1): odd=sample.
- State ODD, on accepted sample: load output register with even=even_q, odd=sample, sof=pending_sof, eol=s_eol_i. Update odd_q <= sample, go EVEN. If s_eol_i, pos <= 0.
- pos counts accepted samples in the current line and increments on every accepted non-eol sample.
- Latency: one cycle from acceptance of the completing sample to m_valid_o=1.
- Throughput: one pair per two input beats.
- sof handling:
  - s_sof_i in state ODD (frame restart mid-pair): discard even_q; the new sample becomes even_q with pending_sof=1; remain ODD; pos <= 1.
  - s_sof_i in state EVEN: no special handling.
- Overlong line: pos reaching MaximumSideSize without eol forces m_eol_o=1 on the pair that completes at that position, and pos <= 0.
- The ready/valid gating guarantees no new pair is loaded while a pair is stalled. A sample arriving while stalled is not accepted.
- Data passes through bit-exact; no arithmetic.

Optional Feature:
- Macro SAMPLE_PAIR_PACKER_ERR_EN.
- Defined: adds port err_o, a registered one-cycle pulse, reset 0. Asserted the cycle after any of:
  - sof received in state ODD;
  - forced eol on overlong line;
  - s_eol_i together with s_sof_i on a sample accepted in state ODD.
- Defined, simulation only: an assertion checks that s_data_i, s_sof_i and s_eol_i stay stable while s_valid_i & !s_ready_o.
- Undefined: err_o absent, no error logic, datapath identical.

Test Plan:
- Line 10,20,30,40 (sof on 10, eol on 40), m_ready_i=1 -> pairs (10,20,sof=1,eol=0), (30,40,sof=0,eol=1); each pair is valid exactly one cycle after its odd sample is accepted.
- Odd-length line 1,2,3,4,5 with eol on 5 -> pairs (1,2), (3,4), (5,4,eol=1). Single-sample line 7 with eol -> (7,7,eol=1).
- Backpressure: m_ready_i=0 for 5 cycles while pair (1,2) is valid -> s_ready_o=0 and outputs stable; release -> (1,2) transferred, then (3,4), no loss or duplication.
- sof mid-pair: 9 (sof), 11 (sof), 12 -> 9 dropped, output (11,12,sof=1); with SAMPLE_PAIR_PACKER_ERR_EN, err_o pulses once.
- rst_ni asserted while ODD with a stalled pair -> m_valid_o=0 immediately (asynchronous). After release, 3,4(eol) -> (3,4,sof=0,eol=1) with no stale data.
- MaximumSideSize=4, samples 1..6 without eol -> pairs (1,2), (3,4,eol=1), then (5,6) starts a new line; err_o pulses when the option is enabled.
